muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Each operation spends 32 cycles in CALC (one product or quotient bit per
// cycle) and one cycle in DONE. The result, rd_out and done are registered
// on the edge that leaves DONE.
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            request an operation; accepted only while busy=0
//   funct3           RV32M op select (MUL..REMU)
//   op_a, op_b       rs1 / rs2 operand values
//   rd_in            destination register index, captured with the operands
//   busy             high while an operation is in CALC or DONE
//   done             one-cycle completion pulse
//   result, rd_out   completed result and register index, held until the next done
//   reg_write        register-file write strobe (done with rd_out != 0)
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [4:0]  rd_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  rd_out,
   output logic        reg_write
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t      r_state, w_next;
   logic [4:0]  r_cnt;
   logic [2:0]  r_f3;
   logic [31:0] r_hi;       // multiply: upper accumulator; divide: partial remainder
   logic [31:0] r_lo;       // multiply: multiplier / low product; divide: dividend / quotient
   logic [31:0] r_mag;      // multiply: multiplicand magnitude; divide: divisor magnitude
   logic [31:0] r_a;        // raw op_a, needed for REM by zero
   logic        r_neg;      // negate product or quotient at DONE
   logic        r_neg_r;    // negate remainder at DONE
   logic        r_div0;
   logic        r_ovf;
   logic [4:0]  r_rd;
   logic [31:0] r_result;
   logic [4:0]  r_rd_out;
   logic        r_done;

   logic        w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
   logic [31:0] w_a_mag, w_b_mag;
   logic [32:0] w_mul_sum;
   logic [32:0] w_div_shift;
   logic        w_div_ge;
   logic [31:0] w_div_diff;
   logic [63:0] w_prod;
   logic [31:0] w_quo, w_rem, w_result;

   // Operand signedness and magnitudes, used only at acceptance
   always_comb begin
      w_a_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
      w_b_sgn = funct3[2] ? ~funct3[0] : ~funct3[1];
      w_a_neg = w_a_sgn & op_a[31];
      w_b_neg = w_b_sgn & op_b[31];
      w_a_mag = w_a_neg ? (~op_a + 32'd1) : op_a;
      w_b_mag = w_b_neg ? (~op_b + 32'd1) : op_b;
   end

   // One iteration step for each algorithm
   always_comb begin
      w_mul_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_mag : 32'd0)};
      w_div_shift = {r_hi, r_lo[31]};
      w_div_ge    = (w_div_shift >= {1'b0, r_mag});
      // When w_div_ge holds the difference is below r_mag, so 32 bits suffice
      w_div_diff  = w_div_shift[31:0] - r_mag;
   end

   // Sign fix-up and special-case selection applied in DONE
   always_comb begin
      w_prod = r_neg ? (~{r_hi, r_lo} + 64'd1) : {r_hi, r_lo};
      w_quo  = r_neg ? (~r_lo + 32'd1) : r_lo;
      w_rem  = r_neg_r ? (~r_hi + 32'd1) : r_hi;
      if (!r_f3[2])
         w_result = (r_f3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];
      else if (r_div0)
         w_result = r_f3[1] ? r_a : '1;
      else if (r_ovf)
         w_result = r_f3[1] ? '0 : 32'h8000_0000;
      else
         w_result = r_f3[1] ? w_rem : w_quo;
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // FSM: next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_CALC;
         S_CALC:  if (r_cnt == 5'd31) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy      = (r_state != S_IDLE);
      done      = r_done;
      result    = r_result;
      rd_out    = r_rd_out;
      reg_write = r_done & (r_rd_out != 5'd0);
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_f3     <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_mag    <= '0;
         r_a      <= '0;
         r_neg    <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_ovf    <= 1'b0;
         r_rd     <= '0;
         r_result <= '0;
         r_rd_out <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cnt   <= '0;
                  r_f3    <= funct3;
                  r_hi    <= '0;
                  r_lo    <= funct3[2] ? w_a_mag : w_b_mag;
                  r_mag   <= funct3[2] ? w_b_mag : w_a_mag;
                  r_a     <= op_a;
                  r_neg   <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  r_div0  <= (op_b == 32'd0);
                  r_ovf   <= funct3[2] & ~funct3[0] &
                             (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
                  r_rd    <= rd_in;
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt + 5'd1;
               if (!r_f3[2]) begin
                  // Shift-add: carry and sum shift right into the product pair
                  r_hi <= w_mul_sum[32:1];
                  r_lo <= {w_mul_sum[0], r_lo[31:1]};
               end else if (w_div_ge) begin
                  r_hi <= w_div_diff;
                  r_lo <= {r_lo[30:0], 1'b1};
               end else begin
                  r_hi <= w_div_shift[31:0];
                  r_lo <= {r_lo[30:0], 1'b0};
               end
            end
            S_DONE: begin
               r_result <= w_result;
               r_rd_out <= r_rd;
               r_done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic [4:0]  rd_in;
   logic        busy, done, reg_write;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   muldiv_unit dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .funct3    (funct3),
      .op_a      (op_a),
      .op_b      (op_b),
      .rd_in     (rd_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .rd_out    (rd_out),
      .reg_write (reg_write)
   );

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model straight from the RV32M rules using wide arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      logic            ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            return $signed(a) / $signed(b);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Caller is #1 after the accepting edge plus e0 further edges
   task automatic wait_done(input int e0, output int lat, output int bcnt,
                            output logic [31:0] res, output logic [4:0] rdo, output logic rw);
      bit found;
      found = 0;
      lat   = e0;
      bcnt  = busy ? 1 : 0;
      res   = '0;
      rdo   = '0;
      rw    = 1'b0;
      while (!found && lat < 60) begin
         @(posedge clk); #1;
         lat++;
         if (done) begin
            found = 1;
            res   = result;
            rdo   = rd_out;
            rw    = reg_write;
         end else if (busy) begin
            bcnt++;
         end
      end
      if (!found) lat = -1;
   endtask

   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                         output logic rw, output int lat, output int bcnt);
      @(negedge clk);
      start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
      @(posedge clk); #1;
      // Scramble inputs after acceptance; the running op must not notice
      start  = 1'b0;
      op_a   = $urandom;
      op_b   = $urandom;
      funct3 = 3'($urandom);
      rd_in  = 5'($urandom);
      wait_done(0, lat, bcnt, res, rdo, rw);
   endtask

   vec_t        vecs[$];
   logic [31:0] res;
   logic [4:0]  rdo;
   logic        rw;
   int          lat, bcnt, npulse;

   initial begin
      rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;

      vecs.push_back('{"mul7x6",     3'd0, 32'd7,          32'd6,          5'd5,  32'd42});
      vecs.push_back('{"mulh_min",   3'd1, 32'h8000_0000,  32'h8000_0000,  5'd1,  32'h4000_0000});
      vecs.push_back('{"mulhu_max",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE});
      vecs.push_back('{"mulhsu",     3'd2, 32'hFFFF_FFFF,  32'd2,          5'd3,  32'hFFFF_FFFF});
      vecs.push_back('{"div_m7_2",   3'd4, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD});
      vecs.push_back('{"rem_m7_2",   3'd6, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF});
      vecs.push_back('{"divu_100_7", 3'd5, 32'd100,        32'd7,          5'd7,  32'd14});
      vecs.push_back('{"remu_100_7", 3'd7, 32'd100,        32'd7,          5'd8,  32'd2});
      vecs.push_back('{"divu_by0",   3'd5, 32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF});
      vecs.push_back('{"rem_by0",    3'd6, 32'd5,          32'd0,          5'd10, 32'd5});
      vecs.push_back('{"div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000});
      vecs.push_back('{"rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0});
      vecs.push_back('{"mul_rd0",    3'd0, 32'd3,          32'd3,          5'd0,  32'd9});

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_rd_out", rd_out, 0);
      chk("rst_reg_write", reg_write, 0);
      @(negedge clk); rst = 1'b0;

      // Table-driven directed vectors
      foreach (vecs[i]) begin
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, res, rdo, rw, lat, bcnt);
         chk({vecs[i].name, "_result"}, res, vecs[i].exp);
         chk({vecs[i].name, "_rd_out"}, rdo, vecs[i].rd);
         chk({vecs[i].name, "_reg_write"}, rw, (vecs[i].rd != 0));
         chk({vecs[i].name, "_latency"}, lat, 33);
         chk({vecs[i].name, "_busy_cycles"}, bcnt, 33);
         @(posedge clk); #1;
         chk({vecs[i].name, "_done_pulse"}, done, 0);
         chk({vecs[i].name, "_result_hold"}, result, vecs[i].exp);
         chk({vecs[i].name, "_rd_hold"}, rd_out, vecs[i].rd);
      end

      // Second start during CALC is ignored, no queuing
      @(negedge clk);
      start = 1'b1; funct3 = 3'd0; op_a = 32'd7; op_b = 32'd6; rd_in = 5'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd9;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(3, lat, bcnt, res, rdo, rw);
      chk("ignored_start_latency", lat, 33);
      chk("ignored_start_result", res, 42);
      chk("ignored_start_rd_out", rdo, 5);
      npulse = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done) npulse++;
      end
      chk("ignored_start_no_queue", npulse, 0);

      // Reset at CALC cycle 10, then an immediate new start
      @(negedge clk);
      start = 1'b1; funct3 = 3'd3; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; rd_in = 5'd17;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_result", result, 0);
      chk("midrst_rd_out", rd_out, 0);
      chk("midrst_reg_write", reg_write, 0);
      rst = 1'b0;
      start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd9;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(0, lat, bcnt, res, rdo, rw);
      chk("postrst_latency", lat, 33);
      chk("postrst_result", res, 14);
      chk("postrst_rd_out", rdo, 9);
      chk("postrst_reg_write", rw, 1);

      // Reset wins over a simultaneous start
      @(negedge clk);
      rst = 1'b1; start = 1'b1; funct3 = 3'd0; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd1;
      @(posedge clk); #1;
      chk("rst_prio_busy", busy, 0);
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      chk("rst_prio_idle", busy, 0);

      // Randomized operations against the reference model
      for (int n = 0; n < 40; n++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         logic [4:0]  rd;
         int          sel;
         f3  = 3'($urandom_range(0, 7));
         rd  = 5'($urandom);
         sel = $urandom_range(0, 7);
         a   = $urandom;
         b   = $urandom;
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
         else if (sel == 3) begin a = -$urandom_range(0, 300); b = -$urandom_range(1, 20); end
         run_op(f3, a, b, rd, res, rdo, rw, lat, bcnt);
         chk($sformatf("rand%0d_f%0d_%h_%h_result", n, f3, a, b), res, ref_model(f3, a, b));
         chk($sformatf("rand%0d_rd_out", n), rdo, rd);
         chk($sformatf("rand%0d_reg_write", n), rw, (rd != 0));
         chk($sformatf("rand%0d_latency", n), lat, 33);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
